mbist_compare_status_collector: RTL

Read-side response checker for the memory BIST assembly: it receives the expected data and compare strobes issued by the BIST controller, aligns them with the memory's read data, and compares each word. It accumulates sticky GO/DONE status, a saturating failure count and first-failure diagnostics. All status is exposed in parallel and through a capture/shift scan register for the IJTAG/TAP access path. It sits between the memory read port and the assembly's status TDR.

---
 rtl/mbist_compare_status_collector.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mbist_compare_status_collector.sv
// mbist_compare_status_collector
// Read-side response checker for the memory BIST assembly. Expected data,
// mask and address travel down an alignment pipeline that matches the
// memory read latency. Each word is compared against the returned read
// data, and the block accumulates sticky GO/DONE, a saturating failure
// count and first-failure diagnostics. All status can be loaded into a
// capture/shift scan register for the TAP access path.
module mbist_compare_status_collector #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int READ_LATENCY   = 1,
  parameter int FAIL_CNT_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      cmp_en_i,
  input  logic [ADDR_WIDTH-1:0]     cmp_addr_i,
  input  logic [DATA_WIDTH-1:0]     exp_data_i,
  input  logic [DATA_WIDTH-1:0]     mask_i,
  input  logic [DATA_WIDTH-1:0]     mem_q_i,
  input  logic                      test_done_i,
  output logic                      go_o,
  output logic                      done_o,
  output logic [FAIL_CNT_WIDTH-1:0] fail_cnt_o,
  output logic [ADDR_WIDTH-1:0]     first_fail_addr_o,
  output logic [DATA_WIDTH-1:0]     first_fail_data_o,
  input  logic                      capture_i,
  input  logic                      shift_i,
  input  logic                      si_i,
  output logic                      so_o
);

  // Scan register holds {done, go, fail_cnt, first_fail_addr, first_fail_data}.
  localparam int SCAN_LEN = 2 + FAIL_CNT_WIDTH + ADDR_WIDTH + DATA_WIDTH;
  // Index of the pipeline stage whose entry is compared this cycle.
  localparam int LAST = READ_LATENCY - 1;
  // DRAIN lasts exactly READ_LATENCY cycles; counter runs 0..READ_LATENCY-1.
  localparam logic [2:0] DRAIN_LAST = 3'(READ_LATENCY - 1);
  localparam logic [FAIL_CNT_WIDTH-1:0] CNT_MAX = {FAIL_CNT_WIDTH{1'b1}};
  localparam logic [FAIL_CNT_WIDTH-1:0] CNT_ONE = FAIL_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A word fails when any unmasked bit differs; mask bit 1 means "don't care".
  function automatic logic f_word_mismatch(
    input logic [DATA_WIDTH-1:0] q,
    input logic [DATA_WIDTH-1:0] exp_w,
    input logic [DATA_WIDTH-1:0] mask_w
  );
    return |((q ^ exp_w) & ~mask_w);
  endfunction

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_drain_cnt;
  logic [2:0] w_drain_cnt_nxt;
  logic       r_done;
  logic       w_accept;

  // Compares are only admitted before the controller signals completion.
  assign w_accept = cmp_en_i & ((r_state == ST_IDLE) | (r_state == ST_RUN));

  // Next-state logic; clear overrides every transition.
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    if (clear_i) begin
      w_state_nxt     = ST_IDLE;
      w_drain_cnt_nxt = 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (test_done_i) begin
            w_state_nxt     = ST_DRAIN;
            w_drain_cnt_nxt = 3'd0;
          end else if (cmp_en_i) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (test_done_i) begin
            w_state_nxt     = ST_DRAIN;
            w_drain_cnt_nxt = 3'd0;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            w_state_nxt     = ST_DONE;
            w_drain_cnt_nxt = 3'd0;
          end else begin
            w_drain_cnt_nxt = r_drain_cnt + 3'd1;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt     = ST_IDLE;
          w_drain_cnt_nxt = 3'd0;
        end
      endcase
    end
  end

  // State, drain counter and registered done flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= 3'd0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  // ---------------------------------------------------------------------
  // Alignment pipeline: expected word, mask and address follow the read
  // ---------------------------------------------------------------------
  logic [READ_LATENCY-1:0]                 r_pv;
  logic [READ_LATENCY-1:0][ADDR_WIDTH-1:0] r_pa;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] r_pe;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] r_pm;

  // Shift compare context toward the stage that meets the read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pv <= '0;
      r_pa <= '0;
      r_pe <= '0;
      r_pm <= '0;
    end else if (clear_i) begin
      r_pv <= '0;
      r_pa <= '0;
      r_pe <= '0;
      r_pm <= '0;
    end else begin
      r_pv[0] <= w_accept;
      r_pa[0] <= cmp_addr_i;
      r_pe[0] <= exp_data_i;
      r_pm[0] <= mask_i;
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pa[k] <= r_pa[k-1];
        r_pe[k] <= r_pe[k-1];
        r_pm[k] <= r_pm[k-1];
      end
    end
  end

  logic w_mismatch;
  assign w_mismatch = r_pv[LAST] & f_word_mismatch(mem_q_i, r_pe[LAST], r_pm[LAST]);

  // ---------------------------------------------------------------------
  // Status accumulation
  // ---------------------------------------------------------------------
  logic                      r_go;
  logic [FAIL_CNT_WIDTH-1:0] r_fail_cnt;
  logic [ADDR_WIDTH-1:0]     r_ff_addr;
  logic [DATA_WIDTH-1:0]     r_ff_data;

  // Sticky go, saturating count; go still high marks the first failure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_go       <= 1'b1;
      r_fail_cnt <= '0;
      r_ff_addr  <= '0;
      r_ff_data  <= '0;
    end else if (clear_i) begin
      r_go       <= 1'b1;
      r_fail_cnt <= '0;
      r_ff_addr  <= '0;
      r_ff_data  <= '0;
    end else if (w_mismatch) begin
      r_go <= 1'b0;
      if (r_fail_cnt != CNT_MAX) begin
        r_fail_cnt <= r_fail_cnt + CNT_ONE;
      end
      if (r_go) begin
        r_ff_addr <= r_pa[LAST];
        r_ff_data <= mem_q_i;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Capture/shift scan register (independent of clear and the FSM)
  // ---------------------------------------------------------------------
  logic [SCAN_LEN-1:0] r_sr;
  logic [SCAN_LEN-1:0] w_scan_load;

  assign w_scan_load = {r_done, r_go, r_fail_cnt, r_ff_addr, r_ff_data};

  // Capture wins over shift; shifting moves data toward bit 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sr <= '0;
    end else if (capture_i) begin
      r_sr <= w_scan_load;
    end else if (shift_i) begin
      r_sr <= {si_i, r_sr[SCAN_LEN-1:1]};
    end
  end

  assign go_o              = r_go;
  assign done_o            = r_done;
  assign fail_cnt_o        = r_fail_cnt;
  assign first_fail_addr_o = r_ff_addr;
  assign first_fail_data_o = r_ff_data;
  assign so_o              = r_sr[0];

endmodule
